// File: rtl/axi4_pkg.sv
// Shared types and constants for the AXI4 write deserialiser.
package axi4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_t;

    localparam int unsigned ADDR_A = 0;
    localparam int unsigned ADDR_B = 1;

    function automatic int unsigned beats(input int unsigned sz, input int unsigned dsz);
        return sz / dsz;
    endfunction

endpackage

// File: rtl/axi4_wr_deser_if.sv
// AW/W/B write channels plus the operand handshake towards the multiply core.
interface axi4_wr_deser_if #(
    parameter int unsigned SZ  = 32,
    parameter int unsigned DSZ = 8,
    parameter int unsigned ASZ = 2
);
    logic [ASZ-1:0] awaddr;
    logic           awvalid;
    logic           awready;
    logic [DSZ-1:0] wdata;
    logic           wvalid;
    logic           wready;
    logic           wlast;
    logic           bresp;
    logic           bvalid;
    logic           bready;
    logic [SZ-1:0]  op_a;
    logic [SZ-1:0]  op_b;
    logic           op_valid;
    logic           op_ready;

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, wlast, bready, op_ready,
        output awready, wready, bresp, bvalid, op_a, op_b, op_valid
    );

    modport master (
        output awaddr, awvalid, wdata, wvalid, wlast, bready, op_ready,
        input  awready, wready, bresp, bvalid, op_a, op_b, op_valid
    );
endinterface

// File: rtl/axi4_beat_packer.sv
// Assembles DSZ-bit beats (LSB first) into an SZ-bit shadow register.
// full is set only when exactly SZ/DSZ beats arrived since the last clr.
module axi4_beat_packer
    import axi4_pkg::*;
#(
    parameter int unsigned SZ  = 32,
    parameter int unsigned DSZ = 8
) (
    input  logic           clk,
    input  logic           _rst,
    input  logic           clr,
    input  logic           en,
    input  logic [DSZ-1:0] din,
    output logic           full,
    output logic [SZ-1:0]  dout
);
    localparam int unsigned BEATS = beats(SZ, DSZ);
    localparam int unsigned IW    = $clog2(BEATS + 1);

    logic [IW-1:0] idx;
    logic          ovf;
    logic [SZ-1:0] shadow;

    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) begin
            idx    <= '0;
            ovf    <= 1'b0;
            shadow <= '0;
        end else if (clr) begin
            idx <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            // Beats past the register width are swallowed but poison the burst.
            if (idx == IW'(BEATS)) begin
                ovf <= 1'b1;
            end else begin
                for (int unsigned i = 0; i < BEATS; i++) begin
                    if (idx == IW'(i)) shadow[i*DSZ +: DSZ] <= din;
                end
                idx <= idx + IW'(1);
            end
        end
    end

    assign full = (idx == IW'(BEATS)) && !ovf;
    assign dout = shadow;

endmodule

// File: rtl/axi4_wr_deser.sv
// AXI4 write slave filling operand registers A/B for the multiply core.
// Optional W-stall timeout is enabled with the AXI4_WSTALL_TIMEOUT_EN macro.
module axi4_wr_deser
    import axi4_pkg::*;
#(
    parameter int unsigned SZ     = 32,
    parameter int unsigned DSZ    = 8,
    parameter int unsigned ASZ    = 2
`ifdef AXI4_WSTALL_TIMEOUT_EN
    ,
    parameter int unsigned TO_CYC = 16
`endif
) (
    input  logic             clk,
    input  logic             _rst,
    axi4_wr_deser_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_DATA = DATA;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]     state;
    logic [ASZ-1:0] addr_q;
    logic           rst_done;
    logic           fa;
    logic           fb;
    logic           op_valid_q;
    logic [SZ-1:0]  op_a_q;
    logic [SZ-1:0]  op_b_q;
    logic [SZ-1:0]  shadow;
    logic           full;
    logic           tmo;
    logic           stall_hit;

    logic aw_rdy;
    logic w_rdy;
    logic b_vld;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic op_hs;
    logic is_a;
    logic mapped;
    logic ok;

    // rst_done keeps awready low while reset is asserted and for the release edge.
    assign aw_rdy = rst_done && (state == ST_IDLE) && !op_valid_q;
    assign w_rdy  = (state == ST_DATA);
    assign b_vld  = (state == ST_RESP);
    assign aw_hs  = aw_rdy && bus.awvalid;
    assign w_hs   = w_rdy && bus.wvalid;
    assign b_hs   = b_vld && bus.bready;
    assign op_hs  = op_valid_q && bus.op_ready;

    assign is_a   = (addr_q == ASZ'(ADDR_A));
    assign mapped = is_a || (addr_q == ASZ'(ADDR_B));
    assign ok     = full && mapped && !tmo;

    axi4_beat_packer #(
        .SZ  (SZ),
        .DSZ (DSZ)
    ) u_packer (
        .clk  (clk),
        ._rst (_rst),
        .clr  (aw_hs),
        .en   (w_hs),
        .din  (bus.wdata),
        .full (full),
        .dout (shadow)
    );

`ifdef AXI4_WSTALL_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] stall_cnt;

    assign stall_hit = (state == ST_DATA) && !bus.wvalid && (stall_cnt == CW'(TO_CYC - 1));

    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) begin
            stall_cnt <= '0;
            tmo       <= 1'b0;
        end else if (aw_hs) begin
            stall_cnt <= '0;
            tmo       <= 1'b0;
        end else if (state == ST_DATA) begin
            if (bus.wvalid) begin
                stall_cnt <= '0;
            end else if (stall_hit) begin
                tmo <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + CW'(1);
            end
        end
    end
`else
    assign stall_hit = 1'b0;
    assign tmo       = 1'b0;
`endif

    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        addr_q <= bus.awaddr;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs && bus.wlast) state <= ST_RESP;
                    else if (stall_hit)    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (b_hs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            fa         <= 1'b0;
            fb         <= 1'b0;
            op_valid_q <= 1'b0;
        end else if (b_hs && ok) begin
            // op_valid rises together with the flag that completes the pair.
            if (is_a) begin
                op_a_q     <= shadow;
                fa         <= 1'b1;
                op_valid_q <= fb;
            end else begin
                op_b_q     <= shadow;
                fb         <= 1'b1;
                op_valid_q <= fa;
            end
        end else if (op_hs) begin
            fa         <= 1'b0;
            fb         <= 1'b0;
            op_valid_q <= 1'b0;
        end
    end

    assign bus.awready  = aw_rdy;
    assign bus.wready   = w_rdy;
    assign bus.bvalid   = b_vld;
    assign bus.bresp    = b_vld && ok;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_valid = op_valid_q;

endmodule

// File: tb/tb_axi4_wr_deser.sv
// Randomised self-checking bench for axi4_wr_deser against a burst-level operand model.
module tb_axi4_wr_deser;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axi4_wr_deser_if #(.SZ(32), .DSZ(8), .ASZ(2)) bus ();

    axi4_wr_deser #(.SZ(32), .DSZ(8), .ASZ(2)) dut (
        .clk  (clk),
        ._rst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    bit          m_fa = 1'b0;
    bit          m_fb = 1'b0;
    bit          m_valid = 1'b0;

    task automatic check_ops(input string tag);
        n_chk++;
        if (bus.op_valid !== m_valid) begin
            n_fail++;
            $display("FAIL %s op_valid: got %b expected %b", tag, bus.op_valid, m_valid);
        end
        n_chk++;
        if (bus.op_a !== m_a) begin
            n_fail++;
            $display("FAIL %s op_a: got %h expected %h", tag, bus.op_a, m_a);
        end
        n_chk++;
        if (bus.op_b !== m_b) begin
            n_fail++;
            $display("FAIL %s op_b: got %h expected %h", tag, bus.op_b, m_b);
        end
    endtask

    // One AW + W burst + B response; the model commits only a mapped, exact-length burst.
    task automatic burst(input logic [1:0] addr, input int unsigned n, input logic [63:0] data,
                         input bit gap, input int unsigned bstall, input string tag);
        int unsigned cnt;
        bit          exp_ok;
        exp_ok = (addr < 2'd2) && (n == 4);
        @(negedge clk);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        cnt = 0;
        while (bus.awready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        n_chk++;
        if (bus.awready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s awready_wait: got %b expected 1", tag, bus.awready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        n_chk++;
        if (bus.wready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wready_latency: got %b expected 1", tag, bus.wready);
        end
        for (int unsigned i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                bus.wvalid = 1'b0;
                bus.wlast  = 1'b0;
                @(negedge clk);
            end
            bus.wdata  = data[i*8 +: 8];
            bus.wvalid = 1'b1;
            bus.wlast  = (i == n - 1);
            cnt = 0;
            while (bus.wready !== 1'b1 && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        n_chk++;
        if (bus.bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s bvalid_latency: got %b expected 1", tag, bus.bvalid);
        end
        n_chk++;
        if (bus.bresp !== exp_ok) begin
            n_fail++;
            $display("FAIL %s bresp: got %b expected %b", tag, bus.bresp, exp_ok);
        end
        for (int unsigned s = 0; s < bstall; s++) begin
            bus.awvalid = 1'b1;
            bus.awaddr  = 2'($urandom_range(0, 1));
            @(negedge clk);
            n_chk++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== exp_ok || bus.awready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s b_stall: got bvalid=%b bresp=%b awready=%b expected 1/%b/0",
                         tag, bus.bvalid, bus.bresp, bus.awready, exp_ok);
            end
        end
        bus.awvalid = 1'b0;
        bus.bready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        if (exp_ok) begin
            if (addr == 2'd0) begin
                m_a  = data[31:0];
                m_fa = 1'b1;
            end else begin
                m_b  = data[31:0];
                m_fb = 1'b1;
            end
            if (m_fa && m_fb) m_valid = 1'b1;
        end
        n_chk++;
        if (bus.bvalid !== 1'b0 || bus.wready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_b: got bvalid=%b wready=%b expected 0/0", tag, bus.bvalid, bus.wready);
        end
        check_ops(tag);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus.op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.op_ready = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_fa    = 1'b0;
            m_fb    = 1'b0;
        end
        n_chk++;
        if (bus.awready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s awready_after_consume: got %b expected 1", tag, bus.awready);
        end
        check_ops(tag);
    endtask

    task automatic test_reset;
        bus.awvalid = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.op_valid} !== 5'b0 ||
            bus.op_a !== 32'h0 || bus.op_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got aw=%b w=%b bv=%b br=%b ov=%b a=%h b=%h expected all 0",
                     bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.op_valid, bus.op_a, bus.op_b);
        end
        rst = 1'b0;
        bus.awvalid = 1'b0;
        #1;
        n_chk++;
        if (bus.awready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_same_cycle awready: got %b expected 0", bus.awready);
        end
        @(negedge clk);
        n_chk++;
        if (bus.awready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_next_cycle awready: got %b expected 1", bus.awready);
        end
    endtask

    task automatic test_load_ab;
        burst(2'd0, 4, 64'h00000000_000027FA, 1'b0, 0, "load_a");
        burst(2'd1, 4, 64'h00000000_00000236, 1'b0, 0, "load_b");
        n_chk++;
        if (bus.op_valid !== 1'b1 || bus.op_a !== 32'h000027FA || bus.op_b !== 32'h00000236) begin
            n_fail++;
            $display("FAIL load_ab_directed: got ov=%b a=%h b=%h expected 1 000027fa 00000236",
                     bus.op_valid, bus.op_a, bus.op_b);
        end
    endtask

    task automatic test_op_handshake;
        repeat (2) @(negedge clk);
        n_chk++;
        if (bus.awready !== 1'b0 || bus.op_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL op_hold: got awready=%b op_valid=%b expected 0/1", bus.awready, bus.op_valid);
        end
        consume("op_consume");
        consume("op_ready_idle");
        burst(2'd0, 4, {32'h0, $urandom}, 1'b0, 0, "a_only");
        burst(2'd0, 4, {32'h0, $urandom}, 1'b0, 0, "a_rewrite");
    endtask

    task automatic test_bad_bursts;
        burst(2'd0, 2, {$urandom, $urandom}, 1'b0, 0, "short_burst");
        burst(2'd0, 6, {$urandom, $urandom}, 1'b0, 0, "long_burst");
        burst(2'd3, 4, {$urandom, $urandom}, 1'b0, 0, "unmapped_3");
        burst(2'd2, 4, {$urandom, $urandom}, 1'b1, 0, "unmapped_2");
    endtask

    task automatic test_backpressure;
        burst(2'd0, 4, {32'h0, $urandom}, 1'b1, 0, "wvalid_gaps");
        burst(2'd1, 4, {32'h0, $urandom}, 1'b0, 5, "bready_stall");
        consume("bp_consume");
    endtask

    task automatic test_random;
        int unsigned r;
        logic [1:0]  addr;
        int unsigned n;
        for (int it = 0; it < 30; it++) begin
            if (m_valid || $urandom_range(0, 4) == 0) consume("rand_consume");
            r = $urandom_range(0, 9);
            addr = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 4;
            burst(addr, n, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), "rand_burst");
        end
    endtask

`ifdef AXI4_WSTALL_TIMEOUT_EN
    task automatic test_timeout;
        int unsigned cnt;
        if (m_valid) consume("to_consume");
        @(negedge clk);
        bus.awaddr  = 2'd1;
        bus.awvalid = 1'b1;
        cnt = 0;
        while (bus.awready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wdata   = 8'hA5;
        bus.wvalid  = 1'b1;
        bus.wlast   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.wvalid = 1'b0;
        cnt = 0;
        while (bus.bvalid !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        n_chk++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== 1'b0 || cnt != 16) begin
            n_fail++;
            $display("FAIL stall_timeout: got bvalid=%b bresp=%b after %0d cycles expected 1/0 after 16",
                     bus.bvalid, bus.bresp, cnt);
        end
        bus.wvalid = 1'b1;
        #1;
        n_chk++;
        if (bus.wready !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_wready: got %b expected 0", bus.wready);
        end
        bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        check_ops("timeout_commit");
    endtask
`endif

    initial begin
        bus.awaddr   = '0;
        bus.awvalid  = 1'b0;
        bus.wdata    = '0;
        bus.wvalid   = 1'b0;
        bus.wlast    = 1'b0;
        bus.bready   = 1'b0;
        bus.op_ready = 1'b0;
        test_reset();
        test_load_ab();
        test_op_handshake();
        test_bad_bursts();
        test_backpressure();
        test_random();
`ifdef AXI4_WSTALL_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
